// File: rtl/mem_dump_ctrl_pkg.sv
// Shared definitions for the data-memory dump responder: FSM state
// encodings and default memory geometry.
package mem_dump_ctrl_pkg;

   // Default data-memory geometry (word address width, word width).
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   // Sweep FSM encodings.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_OUT  = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/mem_dump_ctrl_rise_detect.sv
// One-flop rising-edge detector with synchronous active-high reset.
// Because the history flop clears in reset, a level that is already high
// when reset releases reports one rising edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Remember the previous sample of d.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) d_q <= 1'b0;
      else     d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Memory-dump responder. A rising edge on dump_mem sweeps NUM_WORDS words of
// data memory starting at BASE_ADDR, one synchronous read at a time, and
// streams (address, data) pairs to a valid/ready sink. The core is held
// halted for the whole sweep.
module mem_dump_ctrl
   import mem_dump_ctrl_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BASE_ADDR = 0,
   parameter int NUM_WORDS = 1024,
   parameter int SKIP_ZERO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dump_mem,
   output logic              busy,
   output logic              cpu_halt,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data
);

   // One extra bit over clog2 so NUM_WORDS-1 always fits without overflow.
   localparam int                CNT_W    = $clog2(NUM_WORDS) + 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam bit                SKIP     = (SKIP_ZERO != 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             req;
   logic             last;

   rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (dump_mem),
      .rise (req)
   );

   assign last     = (cnt == LAST_CNT);
   assign cpu_halt = busy;

   // Sweep FSM with registered outputs. busy and mem_rd_en are loaded with
   // the value the next state implies, so they track state exactly. The read
   // address register simply increments, which gives the modulo-2^ADDR_W
   // wrap for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         out_valid   <= 1'b0;
         out_addr    <= '0;
         out_data    <= '0;
      end else begin
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  cnt         <= '0;
                  mem_rd_addr <= BASE;
                  mem_rd_en   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_RD;
               end
            end
            ST_RD: begin
               state <= ST_CAP;
            end
            ST_CAP: begin
               out_data <= mem_rd_data;
               out_addr <= mem_rd_addr;
               if (SKIP && (mem_rd_data == '0)) begin
                  if (last) begin
                     state <= ST_FIN;
                  end else begin
                     cnt         <= cnt + CNT_W'(1);
                     mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                     mem_rd_en   <= 1'b1;
                     state       <= ST_RD;
                  end
               end else begin
                  out_valid <= 1'b1;
                  state     <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last) begin
                     state <= ST_FIN;
                  end else begin
                     cnt         <= cnt + CNT_W'(1);
                     mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                     mem_rd_en   <= 1'b1;
                     state       <= ST_RD;
                  end
               end
            end
            ST_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed bench for mem_dump_ctrl: three instances (plain, skip-zero,
// wrapping window) share one stimulus/monitor path selected by sel.
module tb_mem_dump_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic dump;
   logic ready;
   int   sel;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance A: BASE 8, 4 words, no skipping.
   logic        dump_a, busy_a, halt_a, done_a, rd_en_a, valid_a;
   logic [9:0]  rd_addr_a, addr_a;
   logic [31:0] rd_data_a, data_a;
   // Instance B: same window, SKIP_ZERO=1.
   logic        dump_b, busy_b, halt_b, done_b, rd_en_b, valid_b;
   logic [9:0]  rd_addr_b, addr_b;
   logic [31:0] rd_data_b, data_b;
   // Instance C: ADDR_W=4, BASE 14, wraps.
   logic        dump_c, busy_c, halt_c, done_c, rd_en_c, valid_c;
   logic [3:0]  rd_addr_c, addr_c;
   logic [31:0] rd_data_c, data_c;

   assign dump_a = dump && (sel == 0);
   assign dump_b = dump && (sel == 1);
   assign dump_c = dump && (sel == 2);

   mem_dump_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(8), .NUM_WORDS(4), .SKIP_ZERO(0)) dut_a (
      .clk(clk), .rst(rst), .dump_mem(dump_a), .busy(busy_a), .cpu_halt(halt_a), .done(done_a),
      .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_data(rd_data_a),
      .out_valid(valid_a), .out_ready(ready), .out_addr(addr_a), .out_data(data_a));

   mem_dump_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(8), .NUM_WORDS(4), .SKIP_ZERO(1)) dut_b (
      .clk(clk), .rst(rst), .dump_mem(dump_b), .busy(busy_b), .cpu_halt(halt_b), .done(done_b),
      .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_data(rd_data_b),
      .out_valid(valid_b), .out_ready(ready), .out_addr(addr_b), .out_data(data_b));

   mem_dump_ctrl #(.ADDR_W(4), .DATA_W(32), .BASE_ADDR(14), .NUM_WORDS(4), .SKIP_ZERO(0)) dut_c (
      .clk(clk), .rst(rst), .dump_mem(dump_c), .busy(busy_c), .cpu_halt(halt_c), .done(done_c),
      .mem_rd_en(rd_en_c), .mem_rd_addr(rd_addr_c), .mem_rd_data(rd_data_c),
      .out_valid(valid_c), .out_ready(ready), .out_addr(addr_c), .out_data(data_c));

   // Synchronous-read memory models, data one cycle after the strobe.
   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   logic [31:0] mem_c [0:15];

   always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
   always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
   always @(posedge clk) if (rd_en_c) rd_data_c <= mem_c[rd_addr_c];

   // Monitor view of the selected instance.
   logic        mon_busy, mon_halt, mon_done, mon_rd_en, mon_valid;
   logic [9:0]  mon_rd_addr, mon_addr;
   logic [31:0] mon_data;

   always_comb begin
      mon_busy = busy_a; mon_halt = halt_a; mon_done = done_a; mon_rd_en = rd_en_a;
      mon_valid = valid_a; mon_rd_addr = rd_addr_a; mon_addr = addr_a; mon_data = data_a;
      if (sel == 1) begin
         mon_busy = busy_b; mon_halt = halt_b; mon_done = done_b; mon_rd_en = rd_en_b;
         mon_valid = valid_b; mon_rd_addr = rd_addr_b; mon_addr = addr_b; mon_data = data_b;
      end else if (sel == 2) begin
         mon_busy = busy_c; mon_halt = halt_c; mon_done = done_c; mon_rd_en = rd_en_c;
         mon_valid = valid_c; mon_rd_addr = {6'b0, rd_addr_c}; mon_addr = {6'b0, addr_c};
         mon_data = data_c;
      end
   end

   // Observations collected by run_sweep (cycle 0 is the request cycle).
   int          hs_n, rd_n, first_rd_cyc, first_valid_cyc, done_cyc, done_n, busy_at1;
   logic [9:0]  hs_addr [16];
   logic [31:0] hs_data [16];
   logic [9:0]  rd_log  [16];
   bit          stall_unstable, stall_rd;

   task automatic run_sweep(input int max_cyc, input int stall_addr, input int stall_len,
                            input bit toggle, input bit start);
      logic [9:0]  snap_addr;
      logic [31:0] snap_data;
      int          stall_cnt;
      hs_n = 0; rd_n = 0; first_rd_cyc = -1; first_valid_cyc = -1;
      done_cyc = -1; done_n = 0; busy_at1 = -1;
      stall_unstable = 0; stall_rd = 0; stall_cnt = 0;
      snap_addr = '0; snap_data = '0;
      for (int i = 0; i < 16; i++) begin
         hs_addr[i] = '1; hs_data[i] = '1; rd_log[i] = '1;
      end
      if (start) begin
         @(negedge clk);
         ready = 1'b1;
         dump  = 1'b1;
      end
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (toggle && cyc < 12) dump = !(cyc inside {[2:4], [8:9]});
         if (cyc == 1) busy_at1 = int'(mon_busy);
         if (mon_rd_en) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (rd_n < 16) rd_log[rd_n] = mon_rd_addr;
            rd_n++;
         end
         if (mon_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (mon_done) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_n++;
         end
         if (!ready) begin
            if (mon_rd_en) stall_rd = 1;
            if (!mon_valid || mon_addr !== snap_addr || mon_data !== snap_data) stall_unstable = 1;
         end
         if (mon_valid && int'(mon_addr) == stall_addr && stall_cnt < stall_len) begin
            if (stall_cnt == 0) begin
               snap_addr = mon_addr;
               snap_data = mon_data;
            end
            ready = 1'b0;
            stall_cnt++;
         end else begin
            ready = 1'b1;
            if (mon_valid) begin
               if (hs_n < 16) begin
                  hs_addr[hs_n] = mon_addr;
                  hs_data[hs_n] = mon_data;
               end
               hs_n++;
            end
         end
      end
   endtask

   task automatic go_idle(input int next_sel);
      @(negedge clk);
      dump  = 1'b0;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      sel = next_sel;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; dump = 1'b0; ready = 1'b0; sel = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy_a, halt_a, done_a, rd_en_a, rd_addr_a, valid_a, addr_a, data_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: outputs %b, required all zero",
                  {busy_a, halt_a, done_a, rd_en_a, rd_addr_a, valid_a, addr_a, data_a});
      end
      n_checks++;
      if ({busy_b, done_b, rd_en_b, valid_b, busy_c, done_c, rd_en_c, valid_c, rd_addr_c, addr_c} !== '0) begin
         n_fail++;
         $display("FAIL reset_bc: control outputs nonzero");
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_sweep;
      logic [9:0]  ea [4] = '{10'd8, 10'd9, 10'd10, 10'd11};
      logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      run_sweep(20, -1, 0, 1'b0, 1'b1);
      n_checks++;
      if (first_rd_cyc != 1) begin n_fail++; $display("FAIL basic_first_rd: cycle %0d, required 1", first_rd_cyc); end
      n_checks++;
      if (first_valid_cyc != 3) begin n_fail++; $display("FAIL basic_first_valid: cycle %0d, required 3", first_valid_cyc); end
      n_checks++;
      if (busy_at1 != 1) begin n_fail++; $display("FAIL basic_busy: busy at cycle 1 = %0d, required 1", busy_at1); end
      n_checks++;
      if (hs_n != 4) begin n_fail++; $display("FAIL basic_count: %0d handshakes, required 4", hs_n); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (hs_addr[i] !== ea[i] || hs_data[i] !== ed[i]) begin
            n_fail++;
            $display("FAIL basic_pair%0d: (%0d,%h), required (%0d,%h)", i, hs_addr[i], hs_data[i], ea[i], ed[i]);
         end
      end
      n_checks++;
      if (done_cyc != 14 || done_n != 1) begin
         n_fail++; $display("FAIL basic_done: cycle %0d count %0d, required cycle 14 count 1", done_cyc, done_n);
      end
      n_checks++;
      if (mon_busy !== 1'b0 || mon_halt !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle: busy %b halt %b, required 0 0", mon_busy, mon_halt);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      run_sweep(26, 9, 5, 1'b0, 1'b1);
      n_checks++;
      if (stall_unstable) begin n_fail++; $display("FAIL bp_stable: outputs changed while stalled, required stable (9,22)"); end
      n_checks++;
      if (stall_rd) begin n_fail++; $display("FAIL bp_no_read: mem_rd_en seen while stalled, required none"); end
      n_checks++;
      if (hs_n != 4 || hs_addr[1] !== 10'd9 || hs_data[1] !== ed[1] || hs_data[3] !== ed[3]) begin
         n_fail++; $display("FAIL bp_seq: %0d handshakes, word1 (%0d,%h), required 4 with (9,22)", hs_n, hs_addr[1], hs_data[1]);
      end
      n_checks++;
      if (done_cyc != 19 || done_n != 1) begin
         n_fail++; $display("FAIL bp_done: cycle %0d count %0d, required cycle 19 count 1", done_cyc, done_n);
      end
   endtask

   task automatic test_skip_zero;
      run_sweep(20, -1, 0, 1'b0, 1'b1);
      n_checks++;
      if (hs_n != 2) begin n_fail++; $display("FAIL skip_count: %0d handshakes, required 2", hs_n); end
      n_checks++;
      if (hs_addr[0] !== 10'd8 || hs_data[0] !== 32'h11 || hs_addr[1] !== 10'd11 || hs_data[1] !== 32'h44) begin
         n_fail++; $display("FAIL skip_pairs: (%0d,%h)(%0d,%h), required (8,11)(11,44)",
                            hs_addr[0], hs_data[0], hs_addr[1], hs_data[1]);
      end
      n_checks++;
      if (rd_n != 4) begin n_fail++; $display("FAIL skip_reads: %0d reads, required 4", rd_n); end
      n_checks++;
      if (done_cyc != 12 || done_n != 1) begin
         n_fail++; $display("FAIL skip_done: cycle %0d count %0d, required cycle 12 count 1", done_cyc, done_n);
      end
   endtask

   task automatic test_wrap;
      logic [9:0] ea [4] = '{10'd14, 10'd15, 10'd0, 10'd1};
      run_sweep(20, -1, 0, 1'b0, 1'b1);
      n_checks++;
      if (rd_n != 4) begin n_fail++; $display("FAIL wrap_reads: %0d reads, required 4", rd_n); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rd_log[i] !== ea[i] || hs_addr[i] !== ea[i] || hs_data[i] !== 32'h100 + 32'(ea[i])) begin
            n_fail++; $display("FAIL wrap_word%0d: rd %0d out (%0d,%h), required %0d", i, rd_log[i], hs_addr[i], hs_data[i], ea[i]);
         end
      end
      n_checks++;
      if (done_cyc != 14) begin n_fail++; $display("FAIL wrap_done: cycle %0d, required 14", done_cyc); end
   endtask

   task automatic test_toggle;
      run_sweep(30, -1, 0, 1'b1, 1'b1);
      n_checks++;
      if (hs_n != 4 || done_n != 1 || done_cyc != 14) begin
         n_fail++; $display("FAIL toggle: %0d handshakes %0d dones at %0d, required 4, 1 at 14", hs_n, done_n, done_cyc);
      end
   endtask

   task automatic test_hold_through_reset;
      @(negedge clk);
      rst = 1'b1; dump = 1'b1; ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run_sweep(40, -1, 0, 1'b0, 1'b0);
      n_checks++;
      if (done_n != 1 || hs_n != 4 || done_cyc != 14) begin
         n_fail++; $display("FAIL hold_reset: %0d dones at %0d, %0d handshakes, required 1 at 14, 4", done_n, done_cyc, hs_n);
      end
   endtask

   task automatic test_reset_mid_out;
      int waited;
      @(negedge clk);
      ready = 1'b0; dump = 1'b1;
      waited = 0;
      while (!mon_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (!mon_valid) begin n_fail++; $display("FAIL rst_out_reach: out_valid %b after 10 cycles, required 1", mon_valid); end
      rst = 1'b1; dump = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mon_busy, mon_halt, mon_done, mon_rd_en, mon_rd_addr, mon_valid, mon_addr, mon_data} !== '0) begin
         n_fail++; $display("FAIL rst_out_zero: outputs %b, required all zero",
                            {mon_busy, mon_halt, mon_done, mon_rd_en, mon_rd_addr, mon_valid, mon_addr, mon_data});
      end
      rst = 1'b0;
      run_sweep(20, -1, 0, 1'b0, 1'b0);
      n_checks++;
      if (done_n != 0 || hs_n != 0 || rd_n != 0 || mon_busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_out_quiet: %0d dones %0d handshakes %0d reads busy %b, required none", done_n, hs_n, rd_n, mon_busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < 16; i++) mem_c[i] = 32'h100 + 32'(i);
      mem_a[8] = 32'h11; mem_a[9] = 32'h22; mem_a[10] = 32'h33; mem_a[11] = 32'h44;
      mem_b[8] = 32'h11; mem_b[9] = 32'h0;  mem_b[10] = 32'h0;  mem_b[11] = 32'h44;

      test_reset;
      test_basic_sweep;
      go_idle(0);
      test_backpressure;
      go_idle(1);
      test_skip_zero;
      go_idle(2);
      test_wrap;
      go_idle(0);
      test_toggle;
      go_idle(0);
      test_hold_through_reset;
      go_idle(0);
      test_reset_mid_out;
      go_idle(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Memory-dump responder for the CPU's `dump_mem` request. A rising edge on `dump_mem` starts a sweep over a fixed window of data memory. The block reads each word through the memory's synchronous read port and streams (address, data) pairs out over a valid/ready interface to a sink, either a simulation file writer or a UART framer. It sits inside `Cpu`, next to data memory, and holds the core halted while the sweep runs.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of data memory.
- `DATA_W`, 32: memory word width.
- `BASE_ADDR`, 0: first word address dumped.
- `NUM_WORDS`, 1024: words per dump; legal range 1..2^ADDR_W.
- `SKIP_ZERO`, 0: when 1, words reading as zero are not emitted.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: reset, synchronous, active-high.
- `dump_mem`, in, 1: dump request, level; each rising edge is one request.
- `busy`, out, 1: sweep in progress.
- `cpu_halt`, out, 1: stall to the core; equals `busy`.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `mem_rd_en`, out, 1: memory read strobe.
- `mem_rd_addr`, out, ADDR_W: memory read word address.
- `mem_rd_data`, in, DATA_W: read data; valid exactly one cycle after `mem_rd_en`.
- `out_valid`, out, 1: dump word available.
- `out_ready`, in, 1: sink accepts the word.
- `out_addr`, out, ADDR_W: address of the presented word.
- `out_data`, out, DATA_W: presented word.

## Operation
- Edge detect: `req = dump_mem & ~dump_q`. `dump_q` resets to 0, so a level already high when reset is released triggers exactly one dump.
- FSM states: IDLE, RD, CAP, OUT, FIN.
  - IDLE: on `req`, clear `cnt` and go to RD. Requests in any other state are ignored and are not queued.
  - RD: assert `mem_rd_en` with `mem_rd_addr = BASE_ADDR + cnt`, truncated to ADDR_W (wraps modulo 2^ADDR_W). Go to CAP.
  - CAP: latch `mem_rd_data` into `out_data` and the RD address into `out_addr`.
    - If `SKIP_ZERO` and the data is 0: go to FIN when `cnt == NUM_WORDS-1`, otherwise increment `cnt` and go to RD.
    - Otherwise: set `out_valid` and go to OUT.
  - OUT: hold `out_valid`, `out_addr` and `out_data` stable until `out_valid & out_ready`. On that handshake, clear `out_valid`, then go to FIN if last, otherwise increment `cnt` and go to RD.
  - FIN: `done = 1` for one cycle, then IDLE.
- `cnt` width is clog2(NUM_WORDS)+1, so it cannot overflow.
- `busy = (state != IDLE)`.
- `mem_rd_en` is asserted only in RD, and only one read is in flight at a time.

## Timing
- Reset value of every output is 0: `busy`, `cpu_halt`, `done`, `mem_rd_en`, `mem_rd_addr`, `out_valid`, `out_addr`, `out_data`. State is IDLE, `cnt = 0`, `dump_q = 0`.
- All outputs are registered, except `cpu_halt`, which is wired from the `busy` register.
- Latency and throughput:
  - Edge at cycle t: `req` is seen at t, RD is at t+1, first `out_valid` at t+3.
  - With `out_ready` held high, each word takes 3 cycles.
  - A full sweep takes 3·NUM_WORDS + 2 cycles from the request edge to `done`.
- Backpressure: `out_ready` low holds OUT indefinitely with outputs stable. No reads are issued while waiting.
- `out_ready` is ignored when `out_valid` is 0.
- Reset mid-sweep: the in-flight word is dropped, no `done` is produced, and the block returns to IDLE on the next edge.
- `dump_mem` falling or re-rising during a sweep has no effect. A new dump needs an edge while in IDLE.
- Wrap: with `BASE_ADDR + NUM_WORDS > 2^ADDR_W`, addresses wrap to 0 and continue.

## Structure
- Shared header gets the FSM state encodings (IDLE=0, RD=1, CAP=2, OUT=3, FIN=4) and the default `ADDR_W`/`DATA_W` values, alongside the existing CPU macros.
- One sub-module: `rise_detect`, a one-flop rising-edge detector with synchronous reset. It is reusable for other testbench-driven strobes.
- The remaining logic (FSM, counter, output register) stays flat in `mem_dump_ctrl`.

## Test plan
- Basic sweep: NUM_WORDS=4, BASE_ADDR=8, memory holds words 8..11 = 0x11,0x22,0x33,0x44, `out_ready` held at 1 → 4 handshakes with (8,0x11)..(11,0x44), `done` pulses at cycle t+14, then `busy`=0.
- Backpressure: `out_ready` low for 5 cycles on the second word → `out_valid`, `out_addr`=9 and `out_data`=0x22 stay stable, no `mem_rd_en` pulses occur, and the sequence completes unchanged.
- SKIP_ZERO=1 with words 9 and 10 equal to 0 → only (8,0x11) and (11,0x44) are emitted, and `done` still pulses once.
- Wrap: ADDR_W=4, BASE_ADDR=14, NUM_WORDS=4 → read addresses are 14, 15, 0, 1.
- Request handling:
  - `dump_mem` toggled mid-sweep → ignored.
  - `dump_mem` held high through reset release → exactly one sweep.
  - `rst` asserted during OUT → all outputs 0 on the next cycle and no `done`.
